regfile_write_arbiter: RTL and testbench

- Shares the single regfile write port (ctrl_writeEn / ctrl_writeReg / data_writeReg) between two producers: pipeline writeback (wb) and the multi-cycle mult/div unit (md).
- Valid/ready on each producer side; registered, single-issue output to the regfile.
- Fixed priority to wb, with a starvation guard that forces an md grant after MAX_WAIT blocked cycles.
- Sits between the writeback stage / multdiv unit and `regfile`.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wr_stats.sv | 29 ++
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile write-port arbiter slice.
// Holds the default widths, the hardwired-zero register index and the arbiter state.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    NORMAL,
    FORCE
  } arbState_t;

endpackage

// File: rtl/regfile_wr_stats.sv
// Transfer and conflict counters for the regfile write arbiter.
// Built only when WRARB_STATS_EN is defined.
module regfile_wr_stats (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wbXfer,
  input  logic        mdXfer,
  input  logic        conflict,
  output logic [31:0] stat_wb_cnt,
  output logic [31:0] stat_md_cnt,
  output logic [31:0] stat_conflict_cnt
);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      stat_wb_cnt       <= '0;
      stat_md_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (wbXfer)
        stat_wb_cnt <= stat_wb_cnt + 32'd1;
      if (mdXfer)
        stat_md_cnt <= stat_md_cnt + 32'd1;
      if (conflict)
        stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between writeback and mult/div, wb priority
// with a starvation guard. Optional counters under WRARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              arb_force
`ifdef WRARB_STATS_EN
  ,
  output logic [31:0]       stat_wb_cnt,
  output logic [31:0]       stat_md_cnt,
  output logic [31:0]       stat_conflict_cnt
`endif
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] ZREG = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arbState_t        state;
  logic [CNT_W-1:0] starveCnt;
  logic [CNT_W-1:0] cntNext;
  logic             writeEnQ;
  logic             wbXfer;
  logic             mdXfer;
  logic             mdBlocked;

  always_comb begin
    wb_ready = 1'b0;
    md_ready = 1'b0;
    if (!ctrl_reset) begin
      unique case (state)
        NORMAL: begin
          wb_ready = wb_valid;
          md_ready = md_valid && !wb_valid;
        end
        FORCE: begin
          md_ready = md_valid;
          wb_ready = wb_valid && !md_valid;
        end
        default: ;
      endcase
    end
  end

  assign wbXfer    = wb_valid && wb_ready;
  assign mdXfer    = md_valid && md_ready;
  assign mdBlocked = md_valid && !md_ready
                  && (state == NORMAL);

  always_comb begin
    cntNext = starveCnt;
    if (mdXfer || !md_valid)
      cntNext = '0;
    else if (mdBlocked && starveCnt != CNT_MAX)
      cntNext = starveCnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state         <= NORMAL;
      starveCnt     <= '0;
      writeEnQ      <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      starveCnt <= cntNext;
      unique case (state)
        NORMAL:
          if (cntNext == CNT_MAX)
            state <= FORCE;
        FORCE:
          if (mdXfer || !md_valid)
            state <= NORMAL;
        default:
          state <= NORMAL;
      endcase
      writeEnQ <= 1'b0;
      if (wbXfer && wb_reg != ZREG) begin
        writeEnQ      <= 1'b1;
        ctrl_writeReg <= wb_reg;
        data_writeReg <= wb_data;
      end else if (mdXfer && md_reg != ZREG) begin
        writeEnQ      <= 1'b1;
        ctrl_writeReg <= md_reg;
        data_writeReg <= md_data;
      end
    end
  end

  // reset discards a write already registered for this cycle
  assign ctrl_writeEn = writeEnQ && !ctrl_reset;
  assign arb_force    = (state == FORCE);

`ifdef WRARB_STATS_EN
  regfile_wr_stats uStats (
    .clock             (clock),
    .ctrl_reset        (ctrl_reset),
    .wbXfer            (wbXfer),
    .mdXfer            (mdXfer),
    .conflict          (wb_valid && md_valid),
    .stat_wb_cnt       (stat_wb_cnt),
    .stat_md_cnt       (stat_md_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (MAX_WAIT=4).
// Stats counters are checked when WRARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        arb_force;
`ifdef WRARB_STATS_EN
  logic [31:0] stat_wb_cnt;
  logic [31:0] stat_md_cnt;
  logic [31:0] stat_conflict_cnt;
`endif

  regfile_write_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .MAX_WAIT (4)
  ) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .md_valid      (md_valid),
    .md_reg        (md_reg),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .arb_force     (arb_force)
`ifdef WRARB_STATS_EN
    ,
    .stat_wb_cnt       (stat_wb_cnt),
    .stat_md_cnt       (stat_md_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         sbq[$];
  logic [31:0] rf [32] = '{default: 32'h0};
  int          nChk = 0;
  int          nFail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // simple regfile model fed by the arbiter output
  always @(posedge clock)
    if (ctrl_writeEn === 1'b1)
      rf[ctrl_writeReg] <= data_writeReg;

  // requester contract: held request keeps reg/data stable
  logic        pWbHold = 1'b0;
  logic        pMdHold = 1'b0;
  logic [4:0]  pWbR, pMdR;
  logic [31:0] pWbD, pMdD;
  always @(posedge clock) begin
    if (wb_valid && pWbHold)
      assert (wb_reg == pWbR && wb_data == pWbD)
        else $error("wb requester contract broken");
    if (md_valid && pMdHold)
      assert (md_reg == pMdR && md_data == pMdD)
        else $error("md requester contract broken");
    pWbHold <= wb_valid && !wb_ready;
    pMdHold <= md_valid && !md_ready;
    pWbR <= wb_reg;
    pWbD <= wb_data;
    pMdR <= md_reg;
    pMdD <= md_data;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm,
                     input logic rst,
                     input logic wv,
                     input logic [4:0] wr,
                     input logic [31:0] wd,
                     input logic mv,
                     input logic [4:0] mr,
                     input logic [31:0] mdd,
                     input logic ew,
                     input logic em,
                     input logic ef,
                     input bit keep,
                     input int weExp);
    ctrl_reset = rst;
    wb_valid = wv;
    wb_reg = wr;
    wb_data = wd;
    md_valid = mv;
    md_reg = mr;
    md_data = mdd;
    @(negedge clock);
    chk({nm, ".wbRdy"}, wb_ready, ew);
    chk({nm, ".mdRdy"}, md_ready, em);
    chk({nm, ".force"}, arb_force, ef);
    if (weExp >= 0)
      chk({nm, ".we"}, ctrl_writeEn, weExp != 0);
    if (keep) begin
      if (ew && wr != 5'd0)
        sbq.push_back(wr_t'{r: wr, d: wd});
      if (em && mr != 5'd0)
        sbq.push_back(wr_t'{r: mr, d: mdd});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string nm,
                      input logic rst,
                      input int weExp);
    cyc(nm, rst, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 1, weExp);
  endtask

  localparam logic [31:0] WD = 32'hAAAA0003;
  localparam logic [31:0] MD = 32'hBBBB0007;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_reset = 1'b1;
    wb_valid = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    md_valid = 1'b0;
    md_reg = '0;
    md_data = '0;

    fork
      forever begin
        @(negedge clock);
        if (ctrl_writeEn === 1'b1) begin
          if (sbq.size() == 0) begin
            nChk++;
            nFail++;
            $display("FAIL sb.unexpected: got write r%0d=%0h expected none",
                     ctrl_writeReg, data_writeReg);
          end else begin
            wr_t e;
            e = sbq.pop_front();
            chk("sb.reg", ctrl_writeReg, e.r);
            chk("sb.data", data_writeReg, e.d);
          end
        end
      end
    join_none

    // reset with both requesters pending
    cyc("rst1", 1, 1, 1, 32'h11, 1, 2, 32'h22,
        0, 0, 0, 1, 0);
    chk("rst.reg", ctrl_writeReg, 0);
    chk("rst.data", data_writeReg, 0);
    cyc("rst2", 1, 1, 1, 32'h11, 1, 2, 32'h22,
        0, 0, 0, 1, 0);
    cyc("rel", 0, 1, 1, 32'h11, 1, 2, 32'h22,
        1, 0, 0, 1, 0);
    idle("rel+1", 0, 1);

    // single write and regfile readback
    cyc("single", 0, 1, 5, 32'h0000DEAD, 0, 0, 0,
        1, 0, 0, 1, 0);
    idle("single+1", 0, 1);
    idle("single+2", 0, 0);
    chk("rf5", rf[5], 32'h0000DEAD);

    // r0 write is accepted but dropped
    cyc("r0", 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,
        1, 0, 0, 1, 0);
    idle("r0+1", 0, 0);
    chk("rf0", rf[0], 0);

    // contention: 4 wb grants, forced md grant, wb resumes
    for (int i = 0; i < 4; i++)
      cyc("cont", 0, 1, 3, WD, 1, 7, MD,
          1, 0, 0, 1, -1);
    cyc("contForce", 0, 1, 3, WD, 1, 7, MD,
        0, 1, 1, 1, 1);
    cyc("contResume", 0, 1, 3, WD, 1, 7, MD,
        1, 0, 0, 1, 1);
    idle("contEnd", 0, 1);

    // md drops valid while FORCE: wb served, FORCE exits
    for (int i = 0; i < 4; i++)
      cyc("pre", 0, 1, 3, WD, 1, 7, MD,
          1, 0, 0, 1, -1);
    cyc("dropForce", 0, 1, 3, WD, 0, 7, MD,
        1, 0, 1, 1, 1);
    cyc("dropExit", 0, 1, 3, WD, 0, 7, MD,
        1, 0, 0, 1, 1);
    idle("dropEnd", 0, 1);

    // reset mid-contention clears the starve counter
    cyc("b1", 0, 1, 3, WD, 1, 7, MD, 1, 0, 0, 1, -1);
    cyc("b2", 0, 1, 3, WD, 1, 7, MD, 1, 0, 0, 1, -1);
    cyc("b3", 0, 1, 3, WD, 1, 7, MD, 1, 0, 0, 0, -1);
    cyc("bRst", 1, 1, 3, WD, 1, 7, MD, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc("bPost", 0, 1, 3, WD, 1, 7, MD,
          1, 0, 0, 1, -1);
    cyc("bForce", 0, 1, 3, WD, 1, 7, MD,
        0, 1, 1, 1, -1);
    idle("bEnd", 0, 1);

    // md transfer discarded by reset in the next cycle
    cyc("m1", 0, 0, 0, 0, 1, 9, 32'h99,
        0, 1, 0, 0, 0);
    idle("m2Rst", 1, 0);
    idle("m3", 0, 0);

    // stats scenario: 10 wb, 3 md, 6 conflict cycles
    idle("sRst", 1, 0);
    for (int i = 0; i < 4; i++)
      cyc("s", 0, 1, 3, WD, 1, 7, MD,
          1, 0, 0, 1, -1);
    cyc("sForce", 0, 1, 3, WD, 1, 7, MD,
        0, 1, 1, 1, -1);
    cyc("s6", 0, 1, 3, WD, 1, 7, MD,
        1, 0, 0, 1, -1);
    for (int i = 0; i < 5; i++)
      cyc("sWb", 0, 1, 4, 32'h100 + i, 0, 0, 0,
          1, 0, 0, 1, -1);
    for (int i = 0; i < 2; i++)
      cyc("sMd", 0, 0, 0, 0, 1, 8, 32'h200 + i,
          0, 1, 0, 1, -1);
    idle("sEnd1", 0, -1);
    idle("sEnd2", 0, 0);
`ifdef WRARB_STATS_EN
    chk("statWb", stat_wb_cnt, 10);
    chk("statMd", stat_md_cnt, 3);
    chk("statConflict", stat_conflict_cnt, 6);
`endif
    chk("sbEmpty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
